pong_paddle_ctrl: RTL and testbench

// - Consumer end of the control-rate tick produced by the 50 MHz clock divider: takes the
//   one-cycle ctrl_tick pulse plus raw paddle buttons and produces the paddle Y position for the VGA Pong renderer.
// - Synchronises and debounces the buttons, then moves the paddle with two-speed acceleration, clamped to the screen.
// - Sits between the board buttons / clock divider and the pixel/collision logic. All state is in the clk_50Mhz domain.

---
 rtl/pong_paddle_ctrl.sv | 278 +++++++++++++++++++++++++++
 tb/tb_pong_paddle_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pong_paddle_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : pong_paddle_ctrl
// Brief    : Synchronised/debounced paddle buttons drive a two-speed, screen-clamped
//            paddle position, advanced once per ctrl_tick. Optional macro
//            PONG_PADDLE_AUTO_EN adds auto_en/ball_y ball-tracking mode.
// Revision : 1.0  initial release
// =============================================================================
module pong_paddle_ctrl #(
   parameter int Y_W         = 10,
   parameter int PADDLE_H    = 64,
   parameter int Y_MIN       = 0,
   parameter int Y_MAX       = 416,
   parameter int Y_INIT      = 208,
   parameter int DEB_TICKS   = 4,
   parameter int STEP_SLOW   = 2,
   parameter int STEP_FAST   = 6,
   parameter int ACCEL_TICKS = 16
) (
   input  logic           clk_50Mhz,
   input  logic           rst,
   input  logic           ctrl_tick,
   input  logic           btn_up,
   input  logic           btn_dn,
`ifdef PONG_PADDLE_AUTO_EN
   input  logic           auto_en,
   input  logic [Y_W-1:0] ball_y,
`endif
   output logic [Y_W-1:0] paddle_y,
   output logic           moving,
   output logic           at_top,
   output logic           at_bottom
);

   localparam int             c_DEB_W       = $clog2(DEB_TICKS + 1);
   localparam int             c_HOLD_W      = $clog2(ACCEL_TICKS + 1);
   localparam logic [Y_W-1:0] c_Y_MIN       = Y_W'(Y_MIN);
   localparam logic [Y_W-1:0] c_Y_MAX       = Y_W'(Y_MAX);
   localparam logic [Y_W-1:0] c_Y_INIT      = Y_W'(Y_INIT);
   localparam logic [Y_W:0]   c_Y_MIN_X     = (Y_W+1)'(Y_MIN);
   localparam logic [Y_W:0]   c_Y_MAX_X     = (Y_W+1)'(Y_MAX);
   localparam logic [Y_W:0]   c_STEP_SLOW_X = (Y_W+1)'(STEP_SLOW);
   localparam logic [Y_W:0]   c_STEP_FAST_X = (Y_W+1)'(STEP_FAST);
   localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEB_TICKS - 1);
   localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(ACCEL_TICKS - 2);
   localparam logic           c_TOP_INIT    = (Y_INIT == Y_MIN) ? 1'b1 : 1'b0;
   localparam logic           c_BOT_INIT    = (Y_INIT == Y_MAX) ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DN   = 2'd2
   } dir_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SLOW = 2'd1,
      ST_FAST = 2'd2
   } state_e;

   if ((Y_MAX + PADDLE_H > (1 << Y_W)) || (Y_MIN > Y_MAX)) begin : g_bad_cfg
      $error("pong_paddle_ctrl: clamp range does not fit the paddle on screen");
   end

   // ---------------------------------------------------------------------------
   // Per-button 2-FF synchroniser and tick-rate debouncer (bit 0 = up, 1 = down)
   // ---------------------------------------------------------------------------
   logic [1:0] w_btn_raw;
   logic [1:0] w_deb;

   assign w_btn_raw = {btn_dn, btn_up};

   for (genvar b = 0; b < 2; b++) begin : g_btn
      logic               sync1_q;
      logic               sync2_q;
      logic               deb_q;
      logic               deb_d;
      logic [c_DEB_W-1:0] cnt_q;
      logic [c_DEB_W-1:0] cnt_d;

      always_comb begin
         deb_d = deb_q;
         cnt_d = cnt_q;
         if (ctrl_tick) begin
            if (sync2_q == deb_q) begin
               cnt_d = '0;
            end else if (cnt_q == c_DEB_LAST) begin
               deb_d = ~deb_q;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

      always_ff @(posedge clk_50Mhz or posedge rst) begin
         if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
         end else begin
            sync1_q <= w_btn_raw[b];
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
         end
      end

      assign w_deb[b] = deb_q;
   end

   // ---------------------------------------------------------------------------
   // Requested direction (uses debounced values from before this tick)
   // ---------------------------------------------------------------------------
   state_e              state_q, state_d;
   dir_e                dir_q, dir_d;
   logic [c_HOLD_W-1:0] hold_q, hold_d;
   logic [Y_W-1:0]      y_q, y_d;
   logic                moving_q, at_top_q, at_bottom_q;
   dir_e                w_man_dir;
   dir_e                w_dir;
   logic                w_auto;

   always_comb begin
      w_man_dir = DIR_NONE;
      if (w_deb[0] && !w_deb[1]) begin
         w_man_dir = DIR_UP;
      end else if (w_deb[1] && !w_deb[0]) begin
         w_man_dir = DIR_DN;
      end
   end

`ifdef PONG_PADDLE_AUTO_EN
   localparam logic [Y_W:0] c_HALF_H_X   = (Y_W+1)'(PADDLE_H / 2);
   localparam logic [Y_W:0] c_DEADBAND_X = (Y_W+1)'(4);

   logic [Y_W:0] w_centre;
   logic [Y_W:0] w_ball_x;
   dir_e         w_auto_dir;

   assign w_centre = {1'b0, y_q} + c_HALF_H_X;
   assign w_ball_x = {1'b0, ball_y};
   assign w_auto   = auto_en;

   // ball < centre-4 is written as ball+4 < centre so it cannot underflow
   always_comb begin
      w_auto_dir = DIR_NONE;
      if (w_ball_x + c_DEADBAND_X < w_centre) begin
         w_auto_dir = DIR_UP;
      end else if (w_ball_x > w_centre + c_DEADBAND_X) begin
         w_auto_dir = DIR_DN;
      end
   end

   always_comb begin
      if (auto_en) begin
         w_dir = w_auto_dir;
      end else begin
         w_dir = w_man_dir;
      end
   end
`else
   assign w_auto = 1'b0;
   assign w_dir  = w_man_dir;
`endif

   // ---------------------------------------------------------------------------
   // Motion FSM. hold counts the slow moves of the current run after its first,
   // so the run turns FAST once ACCEL_TICKS slow moves have been made.
   // ---------------------------------------------------------------------------
   logic w_step_en;
   logic w_step_fast;

   always_comb begin
      state_d     = state_q;
      dir_d       = dir_q;
      hold_d      = hold_q;
      w_step_en   = 1'b0;
      w_step_fast = 1'b0;
      if (ctrl_tick) begin
         case (state_q)
            ST_IDLE: begin
               if (w_dir != DIR_NONE) begin
                  state_d   = ST_SLOW;
                  dir_d     = w_dir;
                  hold_d    = '0;
                  w_step_en = 1'b1;
               end
            end
            ST_SLOW: begin
               if (w_dir == DIR_NONE) begin
                  state_d = ST_IDLE;
                  hold_d  = '0;
               end else if (w_dir != dir_q) begin
                  dir_d     = w_dir;
                  hold_d    = '0;
                  w_step_en = 1'b1;
               end else begin
                  w_step_en = 1'b1;
                  if (!w_auto) begin
                     hold_d = hold_q + 1'b1;
                     if (hold_q == c_HOLD_LAST) begin
                        state_d = ST_FAST;
                     end
                  end
               end
            end
            ST_FAST: begin
               if (w_dir == DIR_NONE) begin
                  state_d = ST_IDLE;
                  hold_d  = '0;
               end else if ((w_dir != dir_q) || w_auto) begin
                  state_d   = ST_SLOW;
                  dir_d     = w_dir;
                  hold_d    = '0;
                  w_step_en = 1'b1;
               end else begin
                  w_step_en   = 1'b1;
                  w_step_fast = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               hold_d  = '0;
            end
         endcase
      end
   end

   // Step datapath: one guard bit so neither direction can wrap
   logic [Y_W:0] w_amt;
   logic [Y_W:0] w_floor;
   logic [Y_W:0] w_up_res;
   logic [Y_W:0] w_dn_res;

   always_comb begin
      w_amt    = w_step_fast ? c_STEP_FAST_X : c_STEP_SLOW_X;
      w_floor  = c_Y_MIN_X + w_amt;
      w_up_res = {1'b0, y_q} - w_amt;
      w_dn_res = {1'b0, y_q} + w_amt;
      y_d      = y_q;
      if (w_step_en) begin
         if (dir_d == DIR_UP) begin
            y_d = ({1'b0, y_q} < w_floor) ? c_Y_MIN : w_up_res[Y_W-1:0];
         end else begin
            y_d = (w_dn_res > c_Y_MAX_X) ? c_Y_MAX : w_dn_res[Y_W-1:0];
         end
      end
   end

   always_ff @(posedge clk_50Mhz or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         dir_q       <= DIR_NONE;
         hold_q      <= '0;
         y_q         <= c_Y_INIT;
         moving_q    <= 1'b0;
         at_top_q    <= c_TOP_INIT;
         at_bottom_q <= c_BOT_INIT;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         hold_q      <= hold_d;
         y_q         <= y_d;
         moving_q    <= (state_d != ST_IDLE);
         at_top_q    <= (y_d == c_Y_MIN);
         at_bottom_q <= (y_d == c_Y_MAX);
      end
   end

   assign paddle_y  = y_q;
   assign moving    = moving_q;
   assign at_top    = at_top_q;
   assign at_bottom = at_bottom_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_paddle_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_pong_paddle_ctrl
// Brief    : Directed vector table, clamp/reset sequences and a randomized run
//            against a tick-level behavioural paddle model.
// Revision : 1.0  initial release
// =============================================================================
module tb_pong_paddle_ctrl;

   localparam int Y_MAX  = 416;
   localparam int Y_INIT = 208;

   logic       clk_50Mhz = 1'b0;
   logic       rst;
   logic       ctrl_tick;
   logic       btn_up;
   logic       btn_dn;
   logic [9:0] paddle_y;
   logic       moving;
   logic       at_top;
   logic       at_bottom;
`ifdef PONG_PADDLE_AUTO_EN
   logic       auto_en = 1'b0;
   logic [9:0] ball_y  = 10'd0;
`endif

   int checks   = 0;
   int failures = 0;

   pong_paddle_ctrl dut (
      .clk_50Mhz (clk_50Mhz),
      .rst       (rst),
      .ctrl_tick (ctrl_tick),
      .btn_up    (btn_up),
      .btn_dn    (btn_dn),
`ifdef PONG_PADDLE_AUTO_EN
      .auto_en   (auto_en),
      .ball_y    (ball_y),
`endif
      .paddle_y  (paddle_y),
      .moving    (moving),
      .at_top    (at_top),
      .at_bottom (at_bottom)
   );

   always #5 clk_50Mhz = ~clk_50Mhz;

   typedef struct {
      bit up;
      bit dn;
      int y;
      bit mov;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input bit up, input bit dn, input int y, input bit mov, input int n);
      vec_t v;
      v.up = up; v.dn = dn; v.y = y; v.mov = mov;
      for (int k = 0; k < n; k++) tbl.push_back(v);
   endfunction

   // Reference model: one call per ctrl_tick, button levels already synchronised
   int m_y, m_mode, m_run, m_dir;
   bit m_deb[2];
   int m_cnt[2];

   function automatic void model_reset();
      m_y = Y_INIT; m_mode = 0; m_run = 0; m_dir = 0;
      m_deb[0] = 1'b0; m_deb[1] = 1'b0; m_cnt[0] = 0; m_cnt[1] = 0;
   endfunction

   function automatic void model_tick(input bit up, input bit dn);
      int d;
      int sz;
      bit lvl[2];
      lvl[0] = up; lvl[1] = dn;
      d = (m_deb[0] && !m_deb[1]) ? -1 : ((m_deb[1] && !m_deb[0]) ? 1 : 0);
      for (int b = 0; b < 2; b++) begin
         if (lvl[b] != m_deb[b]) begin
            m_cnt[b]++;
            if (m_cnt[b] == 4) begin
               m_deb[b] = lvl[b];
               m_cnt[b] = 0;
            end
         end else begin
            m_cnt[b] = 0;
         end
      end
      if (d == 0) begin
         m_mode = 0; m_run = 0;
      end else begin
         if (m_mode == 0 || d != m_dir) begin
            m_mode = 1; m_run = 1; m_dir = d; sz = 2;
         end else if (m_mode == 1) begin
            sz = 2; m_run++;
            if (m_run == 16) m_mode = 2;
         end else begin
            sz = 6;
         end
         m_y = m_y + d * sz;
         if (m_y < 0) m_y = 0;
         if (m_y > Y_MAX) m_y = Y_MAX;
      end
   endfunction

   task automatic check(input string name, input int exp_y, input bit exp_mov);
      bit exp_top;
      bit exp_bot;
      exp_top = (exp_y == 0);
      exp_bot = (exp_y == Y_MAX);
      checks++;
      if (paddle_y !== 10'(exp_y) || moving !== exp_mov || at_top !== exp_top || at_bottom !== exp_bot) begin
         failures++;
         $display("FAIL %s: got y=%0d moving=%0b at_top=%0b at_bottom=%0b, expected y=%0d moving=%0b at_top=%0b at_bottom=%0b",
                  name, paddle_y, moving, at_top, at_bottom, exp_y, exp_mov, exp_top, exp_bot);
      end
   endtask

   // gap >= 2 idle clocks lets the synchroniser settle before the tick
   task automatic do_tick(input int gap);
      repeat (gap) @(negedge clk_50Mhz);
      ctrl_tick = 1'b1;
      @(negedge clk_50Mhz);
      ctrl_tick = 1'b0;
   endtask

   initial begin
      int r;
      int len;
      rst = 1'b1; ctrl_tick = 1'b0; btn_up = 1'b0; btn_dn = 1'b0;
      repeat (3) @(negedge clk_50Mhz);
      check("reset_held", Y_INIT, 1'b0);
      rst = 1'b0;
      @(negedge clk_50Mhz);
      check("reset_release", Y_INIT, 1'b0);

      add(0, 0, 208, 0, 2);
      add(0, 1, 208, 0, 3);                               // 3-tick glitch
      add(0, 0, 208, 0, 2);
      add(1, 1, 208, 0, 6);                               // both held
      add(0, 0, 208, 0, 4);
      add(1, 0, 208, 0, 4);                               // debounce of up
      for (int k = 1; k <= 16; k++) add(1, 0, 208 - 2 * k, 1, 1);
      add(1, 0, 170, 1, 1);
      add(1, 0, 164, 1, 1);
      add(0, 1, 158, 1, 1);                               // reversal while FAST
      add(0, 1, 152, 1, 1);
      add(0, 1, 146, 1, 1);
      add(0, 1, 140, 1, 1);
      add(0, 1, 142, 1, 1);
      add(0, 1, 144, 1, 1);
      for (int k = 1; k <= 4; k++) add(0, 0, 144 + 2 * k, 1, 1);
      add(0, 0, 152, 0, 1);

      foreach (tbl[i]) begin
         btn_up = tbl[i].up;
         btn_dn = tbl[i].dn;
         do_tick(2 + (i % 3));
         check($sformatf("vec%0d", i), tbl[i].y, tbl[i].mov);
      end

      btn_up = 1'b1; btn_dn = 1'b0;
      repeat (100) do_tick(2);
      check("top_clamp", 0, 1'b1);
      do_tick(3);
      check("top_no_wrap", 0, 1'b1);
      btn_up = 1'b0; btn_dn = 1'b1;
      repeat (150) do_tick(2);
      check("bottom_clamp", Y_MAX, 1'b1);

      @(negedge clk_50Mhz);
      #2 rst = 1'b1;
      #1 check("async_reset_mid_move", Y_INIT, 1'b0);
      @(negedge clk_50Mhz);
      rst = 1'b0;
      do_tick(2);
      check("post_reset_tick", Y_INIT, 1'b0);

      btn_up = 1'b0; btn_dn = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk_50Mhz);
      rst = 1'b0;
      model_reset();
      for (int s = 0; s < 40; s++) begin
         r   = int'($urandom_range(0, 9));
         len = int'($urandom_range(1, 40));
         btn_up = (r <= 3) || (r == 8);
         btn_dn = (r >= 4) && (r <= 8);
         for (int t = 0; t < len; t++) begin
            do_tick(int'($urandom_range(2, 4)));
            model_tick(btn_up, btn_dn);
            check($sformatf("rand_s%0d_t%0d", s, t), m_y, (m_mode != 0));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
